// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Top-level sequencer for the rectification pipeline. Walks through
//   NUM_STAGES processing stages in order. For each stage it issues a
//   one-cycle start pulse, then waits for that stage's done. After selected
//   stages it can also hold for user confirmation. The user can re-run a
//   stage, abort the run, and recover from a watchdog fault.
//
// Ports
//   clk          system clock
//   reset_n      synchronous, active-low reset
//   button_enter debounced enter button (level); edges are detected here
//   switch       direction select: 1 = forwards, 0 = backwards
//   stage_done   per-stage completion; only bit [stage_idx] is looked at
//   stage_start  one-hot start pulse to stage [stage_idx]
//   stage_idx    current stage
//   phase        IDLE=0 START=1 WAIT=2 HOLD=3 COMPLETE=4 FAULT=5
//   busy         high while in START or WAIT
//   timeout_err  high while in FAULT
module stage_sequencer #(
    parameter int                    NUM_STAGES     = 4,
    parameter int                    IDX_W          = 2,
    parameter logic [NUM_STAGES-1:0] HOLD_MASK      = 4'b0010,
    parameter int                    TIMEOUT_CYCLES = 0,
    parameter int                    TO_W           = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  button_enter,
    input  logic                  switch,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [IDX_W-1:0]      stage_idx,
    output logic [2:0]            phase,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam logic [2:0] PH_IDLE     = 3'd0;
    localparam logic [2:0] PH_START    = 3'd1;
    localparam logic [2:0] PH_WAIT     = 3'd2;
    localparam logic [2:0] PH_HOLD     = 3'd3;
    localparam logic [2:0] PH_COMPLETE = 3'd4;
    localparam logic [2:0] PH_FAULT    = 3'd5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);
    // Last watchdog value before expiry; also the saturation point.
    localparam logic [TO_W-1:0]  TO_LAST  = WDOG_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [2:0]       phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TO_W-1:0]  wdog_q, wdog_d;
    logic             btn_q;

    logic press, fwd, bwd, done_cur, expired;

    // btn_q resets to 1 so a button held through reset is not a press.
    assign press    = button_enter & ~btn_q;
    assign fwd      = press & switch;
    assign bwd      = press & ~switch;
    assign done_cur = stage_done[idx_q];
    assign expired  = WDOG_EN && (wdog_q == TO_LAST);

    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        wdog_d  = wdog_q;
        case (phase_q)
            PH_IDLE: begin
                if (fwd) begin
                    phase_d = PH_START;
                    idx_d   = '0;
                end
            end
            PH_START: begin
                wdog_d  = '0;
                phase_d = PH_WAIT;
            end
            PH_WAIT: begin
                // Done outranks abort and expiry, so a late-but-valid done
                // in the expiry cycle still completes the stage.
                if (done_cur) begin
                    if (HOLD_MASK[idx_q]) begin
                        phase_d = PH_HOLD;
                    end else if (idx_q == LAST_IDX) begin
                        phase_d = PH_COMPLETE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        phase_d = PH_START;
                    end
                end else if (bwd) begin
                    phase_d = PH_IDLE;
                    idx_d   = '0;
                end else if (expired) begin
                    phase_d = PH_FAULT;
                end else if (WDOG_EN && (wdog_q != TO_LAST)) begin
                    wdog_d = wdog_q + TO_W'(1);
                end
            end
            PH_HOLD: begin
                if (fwd) begin
                    if (idx_q == LAST_IDX) begin
                        phase_d = PH_COMPLETE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        phase_d = PH_START;
                    end
                end else if (bwd) begin
                    phase_d = PH_START;
                end
            end
            PH_COMPLETE: begin
                if (bwd) begin
                    phase_d = PH_START;
                    idx_d   = LAST_IDX;
                end else if (fwd) begin
                    phase_d = PH_IDLE;
                    idx_d   = '0;
                end
            end
            PH_FAULT: begin
                if (press) begin
                    phase_d = PH_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                phase_d = PH_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q <= PH_IDLE;
            idx_q   <= '0;
            wdog_q  <= '0;
            btn_q   <= 1'b1;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
            btn_q   <= button_enter;
        end
    end

    always_comb begin
        stage_start = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_start[i] = (phase_q == PH_START) && (idx_q == IDX_W'(i));
        end
    end

    assign stage_idx   = idx_q;
    assign phase       = phase_q;
    assign busy        = (phase_q == PH_START) || (phase_q == PH_WAIT);
    assign timeout_err = (phase_q == PH_FAULT);

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer
//   Directed bench for stage_sequencer with NUM_STAGES=4, HOLD_MASK=4'b0010,
//   TIMEOUT_CYCLES=16. Inputs change 1 time unit after the rising edge and
//   outputs are sampled at the same point, so every sample shows the state
//   produced by the edge just passed.
module tb_stage_sequencer;

    logic       clk;
    logic       reset_n;
    logic       button_enter;
    logic       switch;
    logic [3:0] stage_done;
    logic [3:0] stage_start;
    logic [1:0] stage_idx;
    logic [2:0] phase;
    logic       busy;
    logic       timeout_err;

    int checks;
    int errors;
    int pulses;
    int wait_cnt;

    stage_sequencer #(
        .NUM_STAGES    (4),
        .IDX_W         (2),
        .HOLD_MASK     (4'b0010),
        .TIMEOUT_CYCLES(16),
        .TO_W          (24)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .button_enter(button_enter),
        .switch      (switch),
        .stage_done  (stage_done),
        .stage_start (stage_start),
        .stage_idx   (stage_idx),
        .phase       (phase),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle press; caller must leave at least one cycle with the button
    // low before the next press.
    task automatic press(input logic sw);
        switch       = sw;
        button_enter = 1'b1;
        tick();
        button_enter = 1'b0;
    endtask

    // From START of stage i: two WAIT cycles, then done seen at the third edge.
    task automatic run_stage(input int i);
        tick();
        tick();
        stage_done = 4'(1 << i);
        tick();
        stage_done = 4'b0000;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        button_enter = 1'b1;
        switch       = 1'b1;
        stage_done   = 4'b0000;

        // Reset with the button held high
        tick(); tick(); tick();
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_idx", 32'(stage_idx), 32'd0);
        chk("rst_start", 32'(stage_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);

        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("held_btn_phase", 32'(phase), 32'd0);
        chk("held_btn_start", 32'(stage_start), 32'd0);

        button_enter = 1'b0;
        tick();
        press(1'b0);
        chk("idle_bwd_ignored", 32'(phase), 32'd0);
        tick();

        // Start the run
        press(1'b1);
        chk("s0_start", 32'(stage_start), 32'b0001);
        chk("s0_phase_start", 32'(phase), 32'd1);
        chk("s0_busy", 32'(busy), 32'd1);
        tick();
        chk("s0_pulse_one_cycle", 32'(stage_start), 32'd0);
        chk("s0_phase_wait", 32'(phase), 32'd2);
        tick();
        stage_done = 4'b0001;
        tick();
        stage_done = 4'b0000;
        chk("s1_start", 32'(stage_start), 32'b0010);
        chk("s1_idx", 32'(stage_idx), 32'd1);

        run_stage(1);
        chk("s1_hold", 32'(phase), 32'd3);
        chk("s1_hold_busy", 32'(busy), 32'd0);

        // Re-run stage 1 with the button held for 50 cycles
        switch       = 1'b0;
        button_enter = 1'b1;
        tick();
        chk("rerun_start", 32'(stage_start), 32'b0010);
        chk("rerun_idx", 32'(stage_idx), 32'd1);
        pulses = 0;
        for (int n = 0; n < 49; n++) begin
            stage_done = (n == 2) ? 4'b0010 : 4'b0000;
            tick();
            if (stage_start != 4'b0000) pulses++;
        end
        stage_done   = 4'b0000;
        button_enter = 1'b0;
        tick();
        chk("rerun_single", 32'(pulses), 32'd0);
        chk("rerun_back_hold", 32'(phase), 32'd3);

        press(1'b1);
        chk("s2_start", 32'(stage_start), 32'b0100);
        chk("s2_idx", 32'(stage_idx), 32'd2);
        run_stage(2);
        chk("s3_start", 32'(stage_start), 32'b1000);
        run_stage(3);
        chk("complete_phase", 32'(phase), 32'd4);
        chk("complete_idx", 32'(stage_idx), 32'd3);
        chk("complete_start", 32'(stage_start), 32'd0);

        // Re-run last stage; done arrives in the watchdog expiry cycle
        tick();
        press(1'b0);
        chk("last_rerun_start", 32'(stage_start), 32'b1000);
        for (int n = 0; n < 16; n++) tick();
        chk("expiry_edge_wait", 32'(phase), 32'd2);
        stage_done = 4'b1000;
        tick();
        stage_done = 4'b0000;
        chk("done_vs_expiry_phase", 32'(phase), 32'd4);
        chk("done_vs_expiry_terr", 32'(timeout_err), 32'd0);

        tick();
        press(1'b1);
        chk("complete_fwd_idle", 32'(phase), 32'd0);
        chk("complete_fwd_idx", 32'(stage_idx), 32'd0);

        // Watchdog timeout at stage 2
        tick();
        press(1'b1);
        run_stage(0);
        run_stage(1);
        chk("to_hold", 32'(phase), 32'd3);
        press(1'b1);
        chk("to_s2_start", 32'(stage_start), 32'b0100);
        wait_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (phase == 3'd2) wait_cnt++;
            else break;
        end
        chk("to_wait_cycles", 32'(wait_cnt), 32'd16);
        chk("to_fault_phase", 32'(phase), 32'd5);
        chk("to_terr", 32'(timeout_err), 32'd1);
        chk("to_idx", 32'(stage_idx), 32'd2);
        tick(); tick();
        chk("to_fault_stays", 32'(phase), 32'd5);
        press(1'b0);
        chk("fault_clear_phase", 32'(phase), 32'd0);
        chk("fault_clear_terr", 32'(timeout_err), 32'd0);
        chk("fault_clear_idx", 32'(stage_idx), 32'd0);

        // fwd and foreign done bits ignored in WAIT, bwd aborts
        tick();
        press(1'b1);
        stage_done = 4'b1110;
        tick();
        press(1'b1);
        stage_done = 4'b0000;
        chk("wait_fwd_ignored", 32'(phase), 32'd2);
        chk("wait_fwd_idx", 32'(stage_idx), 32'd0);
        tick();
        press(1'b0);
        chk("abort_phase", 32'(phase), 32'd0);
        chk("abort_idx", 32'(stage_idx), 32'd0);

        // Reset during WAIT of stage 2
        tick();
        press(1'b1);
        run_stage(0);
        run_stage(1);
        press(1'b1);
        tick();
        chk("pre_reset_wait", 32'(phase), 32'd2);
        chk("pre_reset_idx", 32'(stage_idx), 32'd2);
        reset_n = 1'b0;
        tick();
        chk("midrst_phase", 32'(phase), 32'd0);
        chk("midrst_idx", 32'(stage_idx), 32'd0);
        chk("midrst_start", 32'(stage_start), 32'd0);
        reset_n    = 1'b1;
        stage_done = 4'b0100;
        tick(); tick();
        stage_done = 4'b0000;
        chk("late_done_phase", 32'(phase), 32'd0);
        chk("late_done_start", 32'(stage_start), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: bench did not complete");
        $fatal(1, "time limit");
    end

endmodule
